// File: rtl/jam_host.sv
// Host-side driver and checker for the JAM job-assignment engine: buffers an 8x8
// cost matrix, streams it to JAM, then validates the 8-beat assignment answer.
module jam_host #(
   parameter int TIMEOUT = 3000,
   parameter int TO_W    = 12
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ld_valid,
   input  logic [6:0] ld_cost,
   input  logic       start,
   output logic       in_valid,
   output logic [6:0] in_cost,
   input  logic       out_valid,
   input  logic [3:0] out_job,
   input  logic [9:0] out_cost,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_code,
   output logic [9:0] calc_cost
);

   typedef enum logic [2:0] {
      EMPTY, LOAD, READY, SEND, WAIT, RECV, CHECK, DONE
   } state_t;

   state_t state, state_nx;

   logic [6:0]      buffer [64];
   logic [5:0]      ld_cnt;
   logic [5:0]      snd_idx;
   logic [TO_W-1:0] to_cnt;
   logic [2:0]      beat;
   logic [7:0]      seen;
   logic [9:0]      ref_cost;
   logic [9:0]      calc_q;
   logic [2:0]      err_q;

   logic       idle_sel;
   logic       load_beat;
   logic       load_new;
   logic       go;
   logic       beat_take;
   logic       to_expire;
   logic [2:0] beat_idx;
   logic [2:0] job_lo;
   logic       job_ok;
   logic       job_dup;
   logic       cost_bad;
   logic [2:0] beat_err;
   logic [6:0] pick;

   assign idle_sel  = (state == READY) || (state == DONE);
   assign load_beat = ((state == EMPTY) || (state == LOAD)) && ld_valid;
   assign load_new  = idle_sel && ld_valid;
   assign go        = idle_sel && start && !ld_valid;
   assign beat_take = ((state == WAIT) || (state == RECV)) && out_valid;
   assign to_expire = (state == WAIT) && !out_valid && (to_cnt == TO_W'(TIMEOUT - 1));

   // The beat accepted in WAIT is worker 0; RECV then walks workers 1..7.
   assign beat_idx = (state == WAIT) ? 3'd0 : beat;
   assign job_lo   = out_job[2:0] - 3'd1;
   assign job_ok   = (out_job >= 4'd1) && (out_job <= 4'd8);
   assign job_dup  = job_ok && seen[job_lo];
   assign cost_bad = (state == RECV) && (out_cost != ref_cost);
   assign pick     = buffer[{beat_idx, job_lo}];

   always_comb begin
      beat_err = 3'd0;
      if (!job_ok)
         beat_err = 3'd3;
      else if (job_dup)
         beat_err = 3'd4;
      else if (cost_bad)
         beat_err = 3'd6;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= EMPTY;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      in_valid  = 1'b0;
      in_cost   = 7'd0;
      busy      = 1'b0;
      done      = 1'b0;
      pass      = 1'b0;
      err_code  = err_q;
      calc_cost = calc_q;
      case (state)
         EMPTY, LOAD: begin
            if (ld_valid)
               state_nx = (ld_cnt == 6'd63) ? READY : LOAD;
         end
         READY: begin
            if (ld_valid)
               state_nx = LOAD;
            else if (start)
               state_nx = SEND;
         end
         SEND: begin
            in_valid = 1'b1;
            in_cost  = buffer[snd_idx];
            busy     = 1'b1;
            if (snd_idx == 6'd63)
               state_nx = WAIT;
         end
         WAIT: begin
            busy = 1'b1;
            if (out_valid)
               state_nx = RECV;
            else if (to_expire)
               state_nx = DONE;
         end
         RECV: begin
            busy = 1'b1;
            if (!out_valid)
               state_nx = DONE;
            else if (beat == 3'd7)
               state_nx = CHECK;
         end
         CHECK: begin
            busy     = 1'b1;
            state_nx = DONE;
         end
         DONE: begin
            done = 1'b1;
            pass = (err_q == 3'd0);
            if (ld_valid)
               state_nx = LOAD;
            else if (start)
               state_nx = SEND;
         end
         default: state_nx = EMPTY;
      endcase
   end

   // Matrix storage is deliberately not reset so it can be re-sent after DONE.
   always_ff @(posedge clk) begin
      if (load_beat)
         buffer[ld_cnt] <= ld_cost;
      else if (load_new)
         buffer[0] <= ld_cost;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ld_cnt   <= 6'd0;
         snd_idx  <= 6'd0;
         to_cnt   <= '0;
         beat     <= 3'd0;
         seen     <= 8'd0;
         ref_cost <= 10'd0;
         calc_q   <= 10'd0;
         err_q    <= 3'd0;
      end else begin
         if (load_beat)
            ld_cnt <= ld_cnt + 6'd1;
         if (load_new) begin
            ld_cnt <= 6'd1;
            err_q  <= 3'd0;
         end
         if (go) begin
            snd_idx <= 6'd0;
            to_cnt  <= '0;
            beat    <= 3'd0;
            seen    <= 8'd0;
            calc_q  <= 10'd0;
            err_q   <= 3'd0;
         end
         if (state == SEND) begin
            snd_idx <= snd_idx + 6'd1;
            to_cnt  <= '0;
         end
         if ((state == WAIT) && !out_valid) begin
            to_cnt <= to_cnt + 1'b1;
            if (to_expire && (err_q == 3'd0))
               err_q <= 3'd1;
         end
         // Only the first error sticks; later beats still accumulate if legal.
         if (beat_take) begin
            if (state == WAIT)
               ref_cost <= out_cost;
            if (job_ok && !job_dup) begin
               seen[job_lo] <= 1'b1;
               calc_q       <= calc_q + {3'b000, pick};
            end
            if ((err_q == 3'd0) && (beat_err != 3'd0))
               err_q <= beat_err;
            beat <= beat_idx + 3'd1;
         end
         if ((state == RECV) && !out_valid && (err_q == 3'd0))
            err_q <= 3'd2;
         if ((state == CHECK) && (err_q == 3'd0) && (calc_q != ref_cost))
            err_q <= 3'd5;
      end
   end

endmodule

// File: tb/tb_jam_host.sv
// Directed bench for jam_host: drives matrix loads, checks the 64-beat stream
// and the scoreboard verdicts for good and faulty JAM responses.
module tb_jam_host;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       ld_valid = 1'b0;
   logic [6:0] ld_cost = 7'd0;
   logic       start = 1'b0;
   logic       out_valid = 1'b0;
   logic [3:0] out_job = 4'd0;
   logic [9:0] out_cost = 10'd0;
   logic       in_valid;
   logic [6:0] in_cost;
   logic       busy;
   logic       done;
   logic       pass;
   logic [2:0] err_code;
   logic [9:0] calc_cost;

   int checks = 0;
   int failures = 0;

   logic [6:0] mat [64];
   logic [3:0] resp_job [8];
   logic [9:0] resp_cost [8];

   jam_host #(.TIMEOUT(100), .TO_W(12)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ld_valid  (ld_valid),
      .ld_cost   (ld_cost),
      .start     (start),
      .in_valid  (in_valid),
      .in_cost   (in_cost),
      .out_valid (out_valid),
      .out_job   (out_job),
      .out_cost  (out_cost),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .err_code  (err_code),
      .calc_cost (calc_cost)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_diag();
      for (int i = 0; i < 64; i++)
         mat[i] = ((i / 8) == (i % 8)) ? 7'd1 : 7'd50;
   endtask

   task automatic set_ramp();
      for (int i = 0; i < 64; i++)
         mat[i] = 7'(i);
   endtask

   task automatic load_range(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         ld_valid = 1'b1;
         ld_cost  = mat[i];
         step();
      end
      ld_valid = 1'b0;
      ld_cost  = 7'd0;
   endtask

   // Pulses start, then counts stream beats that differ from mat[] plus a
   // non-idle bus on the cycle after the burst.
   task automatic run_stream(output int nbad);
      nbad  = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (in_valid !== 1'b1 || in_cost !== mat[i])
            nbad++;
         step();
      end
      if (in_valid !== 1'b0 || in_cost !== 7'd0)
         nbad++;
   endtask

   task automatic set_resp_ok(input logic [9:0] cost);
      for (int k = 0; k < 8; k++) begin
         resp_job[k]  = 4'(k + 1);
         resp_cost[k] = cost;
      end
   endtask

   task automatic respond(input int n);
      for (int k = 0; k < n; k++) begin
         out_valid = 1'b1;
         out_job   = resp_job[k];
         out_cost  = resp_cost[k];
         step();
      end
      out_valid = 1'b0;
      out_job   = 4'd0;
      out_cost  = 10'd0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      if ({in_valid, busy, done, pass, err_code} !== 7'b0) begin
         failures++;
         $display("[TB] FAIL reset_flags: got %b expected 0000000", {in_valid, busy, done, pass, err_code});
      end
      checks++;
      if ({in_cost, calc_cost} !== 17'd0) begin
         failures++;
         $display("[TB] FAIL reset_data: got in_cost=%0d calc=%0d expected 0/0", in_cost, calc_cost);
      end
      checks++;
      rst_n = 1'b1;
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      if ({busy, in_valid} !== 2'b00) begin
         failures++;
         $display("[TB] FAIL start_in_empty: got busy/in_valid=%b expected 00", {busy, in_valid});
      end
      checks++;
   endtask

   task automatic test_pass();
      int nbad;
      set_diag();
      load_range(0, 63);
      if ({busy, done} !== 2'b00) begin
         failures++;
         $display("[TB] FAIL ready_idle: got busy/done=%b expected 00", {busy, done});
      end
      checks++;
      run_stream(nbad);
      if (nbad !== 0) begin
         failures++;
         $display("[TB] FAIL pass_stream: got %0d bad beats expected 0", nbad);
      end
      checks++;
      set_resp_ok(10'd8);
      respond(8);
      if ({done, busy} !== 2'b01) begin
         failures++;
         $display("[TB] FAIL pass_check_cycle: got done/busy=%b expected 01", {done, busy});
      end
      checks++;
      step();
      if ({done, pass, busy, err_code} !== 6'b110000) begin
         failures++;
         $display("[TB] FAIL pass_verdict: got done=%0d pass=%0d busy=%0d err=%0d expected 1 1 0 0", done, pass, busy, err_code);
      end
      checks++;
      if (calc_cost !== 10'd8) begin
         failures++;
         $display("[TB] FAIL pass_calc: got %0d expected 8", calc_cost);
      end
      checks++;
   endtask

   // Reload from DONE with start asserted on the first load beat, then let JAM time out.
   task automatic test_ramp_timeout();
      int nbad;
      set_ramp();
      ld_valid = 1'b1;
      ld_cost  = mat[0];
      start    = 1'b1;
      step();
      start    = 1'b0;
      if ({in_valid, busy, done, pass} !== 4'b0000) begin
         failures++;
         $display("[TB] FAIL load_beats_start: got %b expected 0000", {in_valid, busy, done, pass});
      end
      checks++;
      load_range(1, 63);
      run_stream(nbad);
      if (nbad !== 0) begin
         failures++;
         $display("[TB] FAIL ramp_stream: got %0d bad beats expected 0", nbad);
      end
      checks++;
      repeat (99) step();
      if ({done, busy} !== 2'b01) begin
         failures++;
         $display("[TB] FAIL timeout_early: got done/busy=%b expected 01", {done, busy});
      end
      checks++;
      step();
      if ({done, pass, busy, err_code} !== 6'b100001) begin
         failures++;
         $display("[TB] FAIL timeout_verdict: got done=%0d pass=%0d busy=%0d err=%0d expected 1 0 0 1", done, pass, busy, err_code);
      end
      checks++;
   endtask

   task automatic test_short_burst();
      int nbad;
      run_stream(nbad);
      if (nbad !== 0) begin
         failures++;
         $display("[TB] FAIL resend_ramp: got %0d bad beats expected 0", nbad);
      end
      checks++;
      if ({busy, done, err_code, calc_cost} !== {2'b10, 3'd0, 10'd0}) begin
         failures++;
         $display("[TB] FAIL start_clears: got busy=%0d done=%0d err=%0d calc=%0d expected 1 0 0 0", busy, done, err_code, calc_cost);
      end
      checks++;
      set_resp_ok(10'd252);
      respond(5);
      step();
      if ({done, pass, err_code} !== 5'b10010) begin
         failures++;
         $display("[TB] FAIL short_verdict: got done=%0d pass=%0d err=%0d expected 1 0 2", done, pass, err_code);
      end
      checks++;
      if (calc_cost !== 10'd90) begin
         failures++;
         $display("[TB] FAIL short_calc: got %0d expected 90", calc_cost);
      end
      checks++;
   endtask

   task automatic test_dup_job();
      int nbad;
      set_diag();
      load_range(0, 63);
      run_stream(nbad);
      if (nbad !== 0) begin
         failures++;
         $display("[TB] FAIL dup_stream: got %0d bad beats expected 0", nbad);
      end
      checks++;
      set_resp_ok(10'd8);
      resp_job[5] = 4'd3;
      respond(8);
      if (done !== 1'b0) begin
         failures++;
         $display("[TB] FAIL dup_early_done: got %0d expected 0", done);
      end
      checks++;
      step();
      if ({done, pass, err_code} !== 5'b10100) begin
         failures++;
         $display("[TB] FAIL dup_verdict: got done=%0d pass=%0d err=%0d expected 1 0 4", done, pass, err_code);
      end
      checks++;
      if (calc_cost !== 10'd7) begin
         failures++;
         $display("[TB] FAIL dup_calc: got %0d expected 7", calc_cost);
      end
      checks++;
   endtask

   task automatic test_mismatch_resend();
      int nbad;
      run_stream(nbad);
      set_resp_ok(10'd9);
      respond(8);
      step();
      if ({done, pass, err_code} !== 5'b10101) begin
         failures++;
         $display("[TB] FAIL mismatch_verdict: got done=%0d pass=%0d err=%0d expected 1 0 5", done, pass, err_code);
      end
      checks++;
      if (calc_cost !== 10'd8) begin
         failures++;
         $display("[TB] FAIL mismatch_calc: got %0d expected 8", calc_cost);
      end
      checks++;
      run_stream(nbad);
      if (nbad !== 0) begin
         failures++;
         $display("[TB] FAIL resend_diag: got %0d bad beats expected 0", nbad);
      end
      checks++;
      set_resp_ok(10'd8);
      respond(8);
      step();
      if ({done, pass, err_code} !== 5'b11000) begin
         failures++;
         $display("[TB] FAIL resend_verdict: got done=%0d pass=%0d err=%0d expected 1 1 0", done, pass, err_code);
      end
      checks++;
   endtask

   // Range error on worker 0 must stay latched over a later duplicate.
   task automatic test_range_unstable();
      int nbad;
      run_stream(nbad);
      set_resp_ok(10'd8);
      resp_job[0] = 4'd9;
      resp_job[6] = 4'd6;
      respond(8);
      step();
      if ({done, err_code, calc_cost} !== {1'b1, 3'd3, 10'd6}) begin
         failures++;
         $display("[TB] FAIL range_verdict: got done=%0d err=%0d calc=%0d expected 1 3 6", done, err_code, calc_cost);
      end
      checks++;
      run_stream(nbad);
      set_resp_ok(10'd8);
      resp_cost[3] = 10'd9;
      respond(8);
      step();
      if ({done, pass, err_code, calc_cost} !== {2'b10, 3'd6, 10'd8}) begin
         failures++;
         $display("[TB] FAIL unstable_verdict: got done=%0d pass=%0d err=%0d calc=%0d expected 1 0 6 8", done, pass, err_code, calc_cost);
      end
      checks++;
   endtask

   task automatic test_reset_mid();
      int nbad;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (30) step();
      if ({in_valid, in_cost} !== {1'b1, 7'd50}) begin
         failures++;
         $display("[TB] FAIL beat30: got in_valid=%0d in_cost=%0d expected 1 50", in_valid, in_cost);
      end
      checks++;
      rst_n = 1'b0;
      #1;
      if ({in_valid, busy, in_cost} !== 9'd0) begin
         failures++;
         $display("[TB] FAIL async_reset: got in_valid=%0d busy=%0d in_cost=%0d expected 0 0 0", in_valid, busy, in_cost);
      end
      checks++;
      step();
      step();
      rst_n = 1'b1;
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      if ({busy, in_valid} !== 2'b00) begin
         failures++;
         $display("[TB] FAIL start_after_reset: got busy/in_valid=%b expected 00", {busy, in_valid});
      end
      checks++;
      set_ramp();
      load_range(0, 9);
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      if ({busy, in_valid} !== 2'b00) begin
         failures++;
         $display("[TB] FAIL start_partial_load: got busy/in_valid=%b expected 00", {busy, in_valid});
      end
      checks++;
      load_range(10, 63);
      run_stream(nbad);
      if (nbad !== 0) begin
         failures++;
         $display("[TB] FAIL reload_stream: got %0d bad beats expected 0", nbad);
      end
      checks++;
      set_resp_ok(10'd252);
      respond(8);
      step();
      if ({done, pass, err_code, calc_cost} !== {2'b11, 3'd0, 10'd252}) begin
         failures++;
         $display("[TB] FAIL reload_verdict: got done=%0d pass=%0d err=%0d calc=%0d expected 1 1 0 252", done, pass, err_code, calc_cost);
      end
      checks++;
   endtask

   initial begin
      #2;
      test_reset();
      test_pass();
      test_ramp_timeout();
      test_short_burst();
      test_dup_job();
      test_mismatch_resend();
      test_range_unstable();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: got no completion expected finish before 300000ns");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
